// File: rtl/mem_watch_if.sv
// Snoop-port and config-port bundle for the mem_watch watchpoint unit.
// Handshakes: a snooped transfer completes on an edge where mon_valid & mon_ready are both high;
// a config request is accepted on every edge where cfg_valid is high and answered by a 1-cycle cfg_ready.
interface mem_watch_if #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int CFG_ADDR_W = 5
);
  logic                  mon_valid;
  logic [ADDR_W-1:0]     mon_addr;
  logic [DATA_W-1:0]     mon_wdata;
  logic [DATA_W/8-1:0]   mon_wstrb;
  logic [DATA_W-1:0]     mon_rdata;
  logic                  mon_ready;
  logic                  cfg_valid;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0]     cfg_wdata;
  logic [3:0]            cfg_wstrb;
  logic [DATA_W-1:0]     cfg_rdata;
  logic                  cfg_ready;
  logic                  hit;
  logic [2:0]            hit_ch;
  logic                  halt;

  modport master (
    output mon_valid, mon_addr, mon_wdata, mon_wstrb, mon_rdata, mon_ready,
    output cfg_valid, cfg_addr, cfg_wdata, cfg_wstrb,
    input  cfg_rdata, cfg_ready, hit, hit_ch, halt
  );

  modport slave (
    input  mon_valid, mon_addr, mon_wdata, mon_wstrb, mon_rdata, mon_ready,
    input  cfg_valid, cfg_addr, cfg_wdata, cfg_wstrb,
    output cfg_rdata, cfg_ready, hit, hit_ch, halt
  );
endinterface

// File: rtl/mem_watch.sv
// Multi-channel memory watchpoint: snoops completed bus transfers, matches N address/mask windows,
// counts hits and captures the last hit. Optional halt request built when MEM_WATCH_HALT_EN is defined.
module mem_watch #(
  parameter int N_CH       = 4,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int CFG_ADDR_W = 5
) (
  input logic        clk,
  input logic        reset,
  mem_watch_if.slave bus
);

  localparam logic [CFG_ADDR_W-1:0] A_STATUS    = CFG_ADDR_W'(4*N_CH);
  localparam logic [CFG_ADDR_W-1:0] A_CAPT_ADDR = CFG_ADDR_W'(4*N_CH + 1);
  localparam logic [CFG_ADDR_W-1:0] A_CAPT_DATA = CFG_ADDR_W'(4*N_CH + 2);

  // Per-channel configuration and statistics
  logic [ADDR_W-1:0] r_addr [N_CH];
  logic [ADDR_W-1:0] r_mask [N_CH];
  logic [N_CH-1:0]   r_en;
  logic [1:0]        r_mode [N_CH];  // [0] qualifies writes, [1] qualifies reads
  logic [CNT_W-1:0]  r_cnt  [N_CH];
  logic [N_CH-1:0]   r_status;
  logic [ADDR_W-1:0] r_capt_addr;
  logic [DATA_W-1:0] r_capt_data;

  // Stage 1: registered transfer and its channel match vector
  logic [N_CH-1:0]   r_s1_match;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_data;

  // Stage 2 / config outputs
  logic              r_hit;
  logic [2:0]        r_hit_ch;
  logic              r_cfg_ready;
  logic [DATA_W-1:0] r_cfg_rdata;

  logic              w_xfer;
  logic              w_mon_wr;
  logic [N_CH-1:0]   w_match;
  logic              w_cfg_wr;
  logic [ADDR_W-1:0] w_wmask_a;
  logic [N_CH-1:0]   w_wr_addr;
  logic [N_CH-1:0]   w_wr_mask;
  logic [N_CH-1:0]   w_wr_ctrl;
  logic [N_CH-1:0]   w_wr_cnt;
  logic [N_CH-1:0]   w_status_clr;
  logic [DATA_W-1:0] w_rdata;
  logic [2:0]        w_low_ch;

`ifdef MEM_WATCH_HALT_EN
  logic [N_CH-1:0] r_halt_en;
  logic [N_CH-1:0] r_s1_halt;
  logic [N_CH-1:0] r_halt_pend;
  logic            r_halt;
`endif

  // Match is taken against the config in force when the transfer is registered,
  // so a same-edge config write only affects later transfers.
  always_comb begin
    w_xfer   = bus.mon_valid & bus.mon_ready;
    w_mon_wr = |bus.mon_wstrb;
    w_match  = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_match[c] = w_xfer & r_en[c]
                 & (((bus.mon_addr ^ r_addr[c]) & r_mask[c]) == '0)
                 & (w_mon_wr ? r_mode[c][0] : r_mode[c][1]);
    end
  end

  always_comb begin
    w_cfg_wr  = bus.cfg_valid & (|bus.cfg_wstrb);
    w_wmask_a = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      w_wmask_a[i] = bus.cfg_wstrb[i/8];
    end
    w_wr_addr = '0;
    w_wr_mask = '0;
    w_wr_ctrl = '0;
    w_wr_cnt  = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_wr_addr[c] = w_cfg_wr && (bus.cfg_addr == CFG_ADDR_W'(4*c));
      w_wr_mask[c] = w_cfg_wr && (bus.cfg_addr == CFG_ADDR_W'(4*c + 1));
      w_wr_ctrl[c] = w_cfg_wr && (bus.cfg_addr == CFG_ADDR_W'(4*c + 2));
      w_wr_cnt[c]  = w_cfg_wr && (bus.cfg_addr == CFG_ADDR_W'(4*c + 3));
    end
    w_status_clr = '0;
    if (w_cfg_wr && (bus.cfg_addr == A_STATUS)) begin
      w_status_clr = bus.cfg_wdata[N_CH-1:0] & {N_CH{bus.cfg_wstrb[0]}};
    end
  end

  // Read mux sees register values before this edge's updates
  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.cfg_addr == CFG_ADDR_W'(4*c))     w_rdata = DATA_W'(r_addr[c]);
      if (bus.cfg_addr == CFG_ADDR_W'(4*c + 1)) w_rdata = DATA_W'(r_mask[c]);
`ifdef MEM_WATCH_HALT_EN
      if (bus.cfg_addr == CFG_ADDR_W'(4*c + 2)) w_rdata = DATA_W'({r_halt_en[c], r_mode[c], r_en[c]});
`else
      if (bus.cfg_addr == CFG_ADDR_W'(4*c + 2)) w_rdata = DATA_W'({1'b0, r_mode[c], r_en[c]});
`endif
      if (bus.cfg_addr == CFG_ADDR_W'(4*c + 3)) w_rdata = DATA_W'(r_cnt[c]);
    end
    if (bus.cfg_addr == A_STATUS)    w_rdata = DATA_W'(r_status);
    if (bus.cfg_addr == A_CAPT_ADDR) w_rdata = DATA_W'(r_capt_addr);
    if (bus.cfg_addr == A_CAPT_DATA) w_rdata = r_capt_data;
  end

  always_comb begin
    w_low_ch = '0;
    for (int c = N_CH-1; c >= 0; c--) begin
      if (r_s1_match[c]) w_low_ch = 3'(c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        r_addr[c] <= '0;
        r_mask[c] <= '0;
        r_mode[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_en        <= '0;
      r_status    <= '0;
      r_capt_addr <= '0;
      r_capt_data <= '0;
      r_s1_match  <= '0;
      r_s1_addr   <= '0;
      r_s1_data   <= '0;
      r_hit       <= 1'b0;
      r_hit_ch    <= '0;
      r_cfg_ready <= 1'b0;
      r_cfg_rdata <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_wr_addr[c]) begin
          r_addr[c] <= (r_addr[c] & ~w_wmask_a) | (bus.cfg_wdata[ADDR_W-1:0] & w_wmask_a);
        end
        if (w_wr_mask[c]) begin
          r_mask[c] <= (r_mask[c] & ~w_wmask_a) | (bus.cfg_wdata[ADDR_W-1:0] & w_wmask_a);
        end
        if (w_wr_ctrl[c] && bus.cfg_wstrb[0]) begin
          r_en[c]   <= bus.cfg_wdata[0];
          r_mode[c] <= bus.cfg_wdata[2:1];
        end
        // Clear beats increment; increment saturates at all-ones
        if (w_wr_cnt[c]) begin
          r_cnt[c] <= '0;
        end else if (r_s1_match[c] && (r_cnt[c] != '1)) begin
          r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        end
      end

      r_status <= (r_status & ~w_status_clr) | r_s1_match;

      r_s1_match <= w_match;
      if (w_xfer) begin
        r_s1_addr <= bus.mon_addr;
        r_s1_data <= w_mon_wr ? bus.mon_wdata : bus.mon_rdata;
      end

      r_hit    <= |r_s1_match;
      r_hit_ch <= w_low_ch;
      if (|r_s1_match) begin
        r_capt_addr <= r_s1_addr;
        r_capt_data <= r_s1_data;
      end

      r_cfg_ready <= bus.cfg_valid;
      r_cfg_rdata <= bus.cfg_valid ? w_rdata : '0;
    end
  end

`ifdef MEM_WATCH_HALT_EN
  // A channel holds halt pending from its hit until its STATUS bit is cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halt_en   <= '0;
      r_s1_halt   <= '0;
      r_halt_pend <= '0;
      r_halt      <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_wr_ctrl[c] && bus.cfg_wstrb[0]) r_halt_en[c] <= bus.cfg_wdata[3];
      end
      r_s1_halt   <= w_match & r_halt_en;
      r_halt_pend <= (r_halt_pend & ~w_status_clr) | r_s1_halt;
      r_halt      <= |r_halt_pend;
    end
  end
  assign bus.halt = r_halt;
`else
  assign bus.halt = 1'b0;
`endif

  assign bus.hit       = r_hit;
  assign bus.hit_ch    = r_hit_ch;
  assign bus.cfg_ready = r_cfg_ready;
  assign bus.cfg_rdata = r_cfg_rdata;

endmodule

// File: tb/tb_mem_watch.sv
// Directed bench for mem_watch: channel matching, pipeline timing, counters, status and halt.
module tb_mem_watch;
  localparam int N_CH       = 4;
  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 4;
  localparam int CFG_ADDR_W = 5;
`ifdef MEM_WATCH_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  int          n_checks = 0;
  int          n_errors = 0;
  int          hits;
  logic [31:0] exp_q[$];

  mem_watch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CFG_ADDR_W(CFG_ADDR_W)) bus ();

  mem_watch #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .CFG_ADDR_W(CFG_ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Driver tasks
  task automatic mon_drive(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.mon_valid = 1'b1;
    bus.mon_ready = 1'b1;
    bus.mon_addr  = a;
    bus.mon_wstrb = s;
    if (s != 4'h0) begin
      bus.mon_wdata = d;
      bus.mon_rdata = 32'hFFFF_FFFF;
    end else begin
      bus.mon_rdata = d;
      bus.mon_wdata = 32'hFFFF_FFFF;
    end
  endtask

  task automatic mon_idle();
    bus.mon_valid = 1'b0;
    bus.mon_ready = 1'b0;
    bus.mon_wstrb = 4'h0;
  endtask

  task automatic cfg_req(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    bus.cfg_wstrb = s;
  endtask

  task automatic cfg_idle();
    bus.cfg_valid = 1'b0;
    bus.cfg_wstrb = 4'h0;
  endtask

  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    cfg_req(a, d, 4'hF);
    tick();
    cfg_idle();
  endtask

  task automatic cfg_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cfg_req(a, 32'h0, 4'h0);
    tick();
    cfg_idle();
    chk({tag, "_rdy"}, 32'(bus.cfg_ready), 32'd1);
    chk(tag, bus.cfg_rdata, exp);
  endtask

  // One isolated transfer; hit expected exactly two cycles later
  task automatic xfer(input string tag, input logic [12:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic exp_hit, input logic [2:0] exp_ch);
    mon_drive(a, d, s);
    tick();
    mon_idle();
    chk({tag, "_lat1"}, 32'(bus.hit), 32'd0);
    tick();
    chk({tag, "_hit"}, 32'(bus.hit), 32'(exp_hit));
    if (exp_hit) chk({tag, "_ch"}, 32'(bus.hit_ch), 32'(exp_ch));
    tick();
    chk({tag, "_pulse"}, 32'(bus.hit), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.mon_addr  = '0;
    bus.mon_wdata = '0;
    bus.mon_rdata = '0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    mon_idle();
    cfg_idle();
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_hit_ch", 32'(bus.hit_ch), 32'd0);
    chk("rst_halt", 32'(bus.halt), 32'd0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    chk("rst_cfg_rdata", bus.cfg_rdata, 32'd0);
    cfg_chk("rst_ctrl0", 5'd2, 32'd0);
    cfg_chk("rst_status", 5'd16, 32'd0);

    // Ch0 exact write watch on 0x1FFA
    cfg_wr(5'd0, 32'h1FFA);
    cfg_wr(5'd1, 32'h1FFF);
    cfg_wr(5'd2, 32'h3);
    cfg_chk("ch0_addr", 5'd0, 32'h1FFA);
    cfg_chk("ch0_ctrl", 5'd2, 32'h3);
    xfer("t1_wr", 13'h1FFA, 32'hDEAD_BEEF, 4'hF, 1'b1, 3'd0);
    cfg_chk("t1_cnt0", 5'd3, 32'd1);
    cfg_chk("t1_capt_data", 5'd18, 32'hDEAD_BEEF);
    cfg_chk("t1_capt_addr", 5'd17, 32'h1FFA);
    cfg_chk("t1_status", 5'd16, 32'h1);
    xfer("t1_rd", 13'h1FFA, 32'h1234_5678, 4'h0, 1'b0, 3'd0);
    xfer("t1_near", 13'h1FFB, 32'h0, 4'hF, 1'b0, 3'd0);
    mon_drive(13'h1FFA, 32'h1, 4'hF);
    bus.mon_ready = 1'b0;
    tick();
    mon_idle();
    tick();
    chk("t1_noready", 32'(bus.hit), 32'd0);
    cfg_chk("t1_cnt0_hold", 5'd3, 32'd1);
    cfg_chk("unmapped", 5'd19, 32'd0);
    cfg_wr(5'd16, 32'hF);
    cfg_wr(5'd2, 32'h0);

    // Ch1 window 0x100-0x1FF, both directions, back-to-back burst
    cfg_wr(5'd4, 32'h100);
    cfg_wr(5'd5, 32'h1F00);
    cfg_wr(5'd6, 32'h7);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        mon_drive(13'(32'h100 + i),
                  (i % 2 == 0) ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i),
                  (i % 2 == 0) ? ((i == 4) ? 4'h1 : 4'hF) : 4'h0);
        exp_q.push_back(32'd1);
      end else begin
        mon_idle();
      end
      tick();
      if (i == 0) chk("b_lat", 32'(bus.hit), 32'd0);
      else begin
        chk("b_hit", 32'(bus.hit), 32'd1);
        chk("b_ch", 32'(bus.hit_ch), exp_q.pop_front());
      end
    end
    tick();
    chk("b_end", 32'(bus.hit), 32'd0);
    cfg_chk("b_cnt1", 5'd7, 32'd5);
    cfg_chk("b_capt_addr", 5'd17, 32'h104);
    cfg_chk("b_capt_data", 5'd18, 32'hA000_0004);
    cfg_chk("b_status", 5'd16, 32'h2);
    cfg_wr(5'd6, 32'h0);
    cfg_wr(5'd16, 32'hF);

    // Ch0 and ch2 overlap on 0x20
    cfg_wr(5'd3, 32'h1234);
    cfg_chk("t3_cnt0_clr", 5'd3, 32'd0);
    cfg_wr(5'd0, 32'h20);
    cfg_wr(5'd2, 32'h3);
    cfg_wr(5'd8, 32'h30);
    cfg_wr(5'd9, 32'h1FE0);
    cfg_wr(5'd10, 32'h7);
    xfer("t3", 13'h020, 32'h55, 4'hF, 1'b1, 3'd0);
    cfg_chk("t3_cnt0", 5'd3, 32'd1);
    cfg_chk("t3_cnt2", 5'd11, 32'd1);
    cfg_chk("t3_cnt1", 5'd7, 32'd5);
    cfg_chk("t3_status", 5'd16, 32'h5);
    cfg_wr(5'd16, 32'h1);
    cfg_chk("t3_w1c", 5'd16, 32'h4);

    // Saturation with a 4-bit counter
    hits = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) mon_drive(13'h020, 32'(i), 4'hF);
      else mon_idle();
      tick();
      if (bus.hit) hits++;
    end
    chk("sat_hits", 32'(hits), 32'd20);
    cfg_chk("sat_cnt0", 5'd3, 32'd15);
    cfg_chk("sat_cnt2", 5'd11, 32'd15);

    // COUNT clear on the same edge as an increment
    cfg_wr(5'd11, 32'h0);
    mon_drive(13'h030, 32'h1, 4'hF);
    tick();
    mon_idle();
    cfg_req(5'd11, 32'h0, 4'hF);
    tick();
    cfg_idle();
    chk("se_hit", 32'(bus.hit), 32'd1);
    chk("se_ch", 32'(bus.hit_ch), 32'd2);
    cfg_chk("se_cnt2", 5'd11, 32'd0);

    // Read on the increment edge returns the old count
    mon_drive(13'h030, 32'h2, 4'hF);
    tick();
    mon_idle();
    cfg_req(5'd11, 32'h0, 4'h0);
    tick();
    cfg_idle();
    chk("rbu_old", bus.cfg_rdata, 32'd0);
    cfg_chk("rbu_new", 5'd11, 32'd1);

    // STATUS set beats W1C on the same edge
    cfg_wr(5'd16, 32'hF);
    cfg_chk("st_clr", 5'd16, 32'h0);
    mon_drive(13'h030, 32'h3, 4'hF);
    tick();
    mon_idle();
    cfg_req(5'd16, 32'h4, 4'hF);
    tick();
    cfg_idle();
    tick();
    cfg_chk("st_setwins", 5'd16, 32'h4);

    // CTRL write on the edge a transfer registers: that transfer uses the old config
    mon_drive(13'h020, 32'h77, 4'hF);
    cfg_req(5'd2, 32'h0, 4'hF);
    tick();
    cfg_idle();
    mon_drive(13'h020, 32'h78, 4'hF);
    tick();
    mon_idle();
    chk("cc_hit1", 32'(bus.hit), 32'd1);
    chk("cc_ch1", 32'(bus.hit_ch), 32'd0);
    tick();
    chk("cc_hit2", 32'(bus.hit), 32'd1);
    chk("cc_ch2", 32'(bus.hit_ch), 32'd2);
    tick();
    chk("cc_end", 32'(bus.hit), 32'd0);
    cfg_chk("cc_capt", 5'd18, 32'h78);

    // Halt request from ch3
    cfg_wr(5'd12, 32'h40);
    cfg_wr(5'd13, 32'h1FFF);
    cfg_wr(5'd14, 32'hB);
    cfg_chk("ctrl3", 5'd14, HALT_ON ? 32'hB : 32'h3);
    mon_drive(13'h040, 32'h99, 4'hF);
    tick();
    mon_idle();
    tick();
    chk("h_hit", 32'(bus.hit), 32'd1);
    chk("h_ch", 32'(bus.hit_ch), 32'd3);
    chk("h_halt_early", 32'(bus.halt), 32'd0);
    tick();
    chk("h_halt_rise", 32'(bus.halt), 32'(HALT_ON));
    repeat (2) tick();
    chk("h_halt_hold", 32'(bus.halt), 32'(HALT_ON));
    cfg_chk("h_status", 5'd16, 32'hD);
    cfg_wr(5'd16, 32'h8);
    tick();
    chk("h_halt_fall", 32'(bus.halt), 32'd0);
    cfg_chk("h_status_post", 5'd16, 32'h5);

    // Reset with a matching transfer in stage 1 and a config read in flight
    mon_drive(13'h030, 32'h5A, 4'hF);
    tick();
    mon_idle();
    reset = 1'b1;
    cfg_req(5'd16, 32'h0, 4'h0);
    tick();
    reset = 1'b0;
    cfg_idle();
    chk("mr_hit", 32'(bus.hit), 32'd0);
    chk("mr_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    chk("mr_halt", 32'(bus.halt), 32'd0);
    tick();
    chk("mr_hit2", 32'(bus.hit), 32'd0);
    cfg_chk("mr_status", 5'd16, 32'h0);
    cfg_chk("mr_cnt2", 5'd11, 32'd0);
    cfg_chk("mr_cnt0", 5'd3, 32'd0);
    cfg_chk("mr_ctrl2", 5'd10, 32'd0);
    cfg_chk("mr_addr2", 5'd8, 32'd0);
    cfg_chk("mr_capt", 5'd18, 32'd0);
    xfer("mr_post", 13'h040, 32'h1, 4'hF, 1'b0, 3'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_watch.md
# mem_watch

Multi-channel memory watchpoint unit for the SoC native memory bus, the synthesizable successor of the single-address SRAM write monitor in the system testbench. It passively snoops completed transfers on one CPU-to-memory port and matches them against N programmable address/mask windows, each qualified by read, write or both. It keeps per-channel saturating hit counters and captures the address and data of the most recent hit. Hits are signalled to the bench or SoC as a pulse plus sticky status, and optionally as a halt request.

## Interface
Parameters:
- N_CH, 4, number of watch channels (1..8)
- ADDR_W, 13, monitored word-address width
- DATA_W, 32, monitored data width
- CNT_W, 16, hit counter width
- CFG_ADDR_W, 5, config register word-address width; must cover 4*N_CH+3 registers

Ports:
- clk  in  1  system clock
- reset  in  1  reset; one clock, synchronous, active-high
- mon_valid  in  1  snooped request valid
- mon_addr  in  ADDR_W  snooped word address
- mon_wdata  in  DATA_W  snooped write data
- mon_wstrb  in  DATA_W/8  snooped write strobes; all-zero means read
- mon_rdata  in  DATA_W  snooped read data, valid with mon_ready
- mon_ready  in  1  snooped transfer completes when mon_valid & mon_ready
- cfg_valid  in  1  config bus request
- cfg_addr  in  CFG_ADDR_W  config register word address
- cfg_wdata  in  DATA_W  config write data
- cfg_wstrb  in  4  config write strobes; all-zero means read
- cfg_rdata  out  DATA_W  config read data
- cfg_ready  out  1  config transfer done
- hit  out  1  one-cycle pulse per matched transfer
- hit_ch  out  3  lowest matching channel index, valid with hit
- halt  out  1  halt request (see Configuration)

## Operation
- Register map, channel c at word 4c: +0 ADDR, +1 MASK (1 = compare the bit), +2 CTRL {bit0 en, bits2:1 mode: 01 write, 10 read, 11 both, 00 none; bit3 halt_en}, +3 COUNT (read: count; any write clears it).
- Global registers: 4*N_CH STATUS (bit c sticky hit for channel c, write 1 to clear), +1 CAPT_ADDR, +2 CAPT_DATA. Unmapped reads return 0; unmapped writes are ignored.
- Match for channel c on a completed transfer: en & ((mon_addr ^ ADDR) & MASK) == 0 & mode-qualified. A write qualifies on mode bit1 and uses wdata; a read qualifies on mode bit2 and uses rdata.
- Stage 1 registers the transfer: addr, data selected by direction, direction. Stage 2 evaluates all channels in parallel.
- On any match: hit=1; hit_ch = lowest matching c; every matching channel increments COUNT, saturating at 2^CNT_W-1, and sets STATUS[c]; CAPT_ADDR/CAPT_DATA load the registered addr and data.
- Sub-word writes: CAPT_DATA holds mon_wdata unmasked.

## Timing
- Reset values: cfg_rdata=0, cfg_ready=0, hit=0, hit_ch=0, halt=0. All registers reset to 0, so every channel is disabled.
- Hit latency: hit asserts 2 cycles after the mon_valid&mon_ready edge. Back-to-back transfers give back-to-back hit pulses, with no loss.
- Config access: cfg_ready pulses exactly 1 cycle after cfg_valid is sampled, with cfg_rdata valid in that cycle. A new request may follow immediately.
- Reading a register returns its value before any same-edge update.
- Same-edge conflicts:
  - COUNT clear wins over increment.
  - STATUS set wins over W1C clear.
  - A config write to ADDR/MASK/CTRL affects only transfers registered after that edge.
- reset mid-operation clears all pipeline stages; no hit is emitted for in-flight transfers.

## Configuration
- MEM_WATCH_HALT_EN defined:
  - halt rises on the cycle after any hit whose matching channel has halt_en=1.
  - halt stays high until every such STATUS bit is cleared; it then falls 1 cycle after the clearing write.
- Undefined: halt is tied to 0, CTRL bit3 reads 0, and no halt logic is synthesized.

## Test plan
- Ch0 ADDR=0x1FFA, MASK=0x1FFF, mode=01; write to 0x1FFA data 0xDEADBEEF -> hit at +2, hit_ch=0, COUNT0=1, CAPT_DATA=0xDEADBEEF; a read of 0x1FFA gives no hit.
- Ch1 ADDR=0x100, MASK=0x1F00, mode=11; 5 consecutive transfers to 0x100..0x104 -> 5 consecutive hit pulses, COUNT1=5, CAPT_ADDR=0x104.
- Ch0 and ch2 both match address 0x20 -> hit_ch=0, both counts increment, STATUS=0b101; write STATUS=0b001 -> STATUS=0b100.
- CNT_W=4 with 20 matching writes -> COUNT=15 (saturated); COUNT write on the same edge as a hit -> COUNT reads 0.
- MEM_WATCH_HALT_EN with ch3 halt_en=1 -> halt=1 at +3 after the hit; clearing STATUS[3] -> halt=0 the next cycle; a build without the macro keeps halt=0.
- Assert reset while a matching transfer is in stage 1 -> no hit, all registers 0, cfg_ready=0.
